// File: rtl/clockgen_seq_pkg.sv
// Shared types and default timing for the clock generator lock sequencer.
// Contents:
//   state_e   - sequencer FSM states
//   *_DEF     - default cycle counts for a 14.318181 MHz sequencer clock
package clockgen_seq_pkg;

   typedef enum logic [2:0] {
      StRstMmcm,
      StWaitLock,
      StStable,
      StRun,
      StDrain,
      StFail
   } state_e;

   // Shared cycle counter width; every cycle-count parameter must fit below 2^CNT_W.
   localparam int unsigned CNT_W_DEF         = 24;

   localparam int unsigned RST_CYCLES_DEF    = 16;     // MMCM reset pulse width
   localparam int unsigned LOCK_TIMEOUT_DEF  = 14318;  // ~1 ms lock wait per attempt
   localparam int unsigned STABLE_CYCLES_DEF = 1432;   // ~100 us of continuous lock
   localparam int unsigned MAX_RETRY_DEF     = 3;
   localparam int unsigned DRAIN_CYCLES_DEF  = 64;
   localparam bit          DEFAULT_SEL_DEF   = 1'b0;

endpackage

// File: rtl/clockgen_lock_sequencer_if.sv
// Control/status bundle between the lock sequencer and its surroundings.
// Signals:
//   locked       - MMCM LOCKED (asynchronous to the sequencer clock)
//   restart_req  - one-cycle pulse, force a full re-sequence
//   sel_valid    - one-cycle pulse, request clk_sel = sel_req
//   sel_req      - requested clock source
//   mmcm_reset   - MMCM RST
//   sys_reset    - reset for the dot-clock domain
//   clk_sel      - clock-source select
//   running/fail - status flags
//   sel_busy     - sel_valid would be dropped right now
//   retry_count  - retries used by current/most recent sequence
//   loss_count   - saturating count of lock losses while running
// Modports: master drives requests and locked; slave is the sequencer.
interface clockgen_lock_sequencer_if;

   logic       locked;
   logic       restart_req;
   logic       sel_valid;
   logic       sel_req;
   logic       mmcm_reset;
   logic       sys_reset;
   logic       clk_sel;
   logic       running;
   logic       fail;
   logic       sel_busy;
   logic [3:0] retry_count;
   logic [7:0] loss_count;

   modport master (
      output locked, restart_req, sel_valid, sel_req,
      input  mmcm_reset, sys_reset, clk_sel, running, fail, sel_busy, retry_count, loss_count
   );

   modport slave (
      input  locked, restart_req, sel_valid, sel_req,
      output mmcm_reset, sys_reset, clk_sel, running, fail, sel_busy, retry_count, loss_count
   );

endinterface

// File: rtl/clockgen_lock_sequencer_sync_2ff.sv
// Generic two-flop synchronizer with synchronous active-high reset.
// Ports:
//   clk   - destination clock
//   reset - synchronous, active-high; forces q to RESET_VAL
//   d     - asynchronous input
//   q     - synchronized output, two cycles of latency
module sync_2ff #(
   parameter bit RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/clockgen_lock_sequencer.sv
// Lock sequencer for the MMCM dot4x/col16x clock generator.
// Pulses MMCM reset, waits (with timeout and bounded retries) for a synchronized LOCKED,
// requires lock to hold for STABLE_CYCLES before releasing sys_reset, and re-sequences on
// lock loss, restart, or a clock-source change (applied only while sys_reset is held).
// Ports:
//   clk_in14mhz - free-running crystal clock, sequencer clock
//   reset       - synchronous, active-high
//   bus         - control/status bundle (slave side), see clockgen_lock_sequencer_if
module clockgen_lock_sequencer
   import clockgen_seq_pkg::*;
#(
   parameter int unsigned RST_CYCLES    = RST_CYCLES_DEF,
   parameter int unsigned LOCK_TIMEOUT  = LOCK_TIMEOUT_DEF,
   parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
   parameter int unsigned MAX_RETRY     = MAX_RETRY_DEF,
   parameter int unsigned DRAIN_CYCLES  = DRAIN_CYCLES_DEF,
   parameter bit          DEFAULT_SEL   = DEFAULT_SEL_DEF,
   parameter int unsigned CNT_W         = CNT_W_DEF
) (
   input logic                      clk_in14mhz,
   input logic                      reset,
   clockgen_lock_sequencer_if.slave bus
);

   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_CYCLES - 1);
   localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRY);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       retry_q, retry_d;
   logic [7:0]       loss_q, loss_d;
   logic             sel_q, sel_d;
   logic             pend_q, pend_d;
   logic             mmcm_reset_q, sys_reset_q, running_q, fail_q, sel_busy_q;
   logic             locked_s;

   sync_2ff #(
      .RESET_VAL(1'b0)
   ) u_sync_locked (
      .clk  (clk_in14mhz),
      .reset(reset),
      .d    (bus.locked),
      .q    (locked_s)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      retry_d = retry_q;
      loss_d  = loss_q;
      sel_d   = sel_q;
      pend_d  = pend_q;
      unique case (state_q)
         StRstMmcm: begin
            if (cnt_q == RST_LAST) begin
               state_d = StWaitLock;
               cnt_d   = '0;
            end
         end
         StWaitLock: begin
            if (locked_s) begin
               state_d = StStable;
               cnt_d   = '0;
            end else if (cnt_q == TIMEOUT_LAST) begin
               cnt_d = '0;
               if (retry_q == RETRY_MAX) begin
                  state_d = StFail;
               end else begin
                  retry_d = retry_q + 4'd1;
                  state_d = StRstMmcm;
               end
            end
         end
         StStable: begin
            // Any dropout restarts the lock wait without consuming a retry.
            if (!locked_s) begin
               state_d = StWaitLock;
               cnt_d   = '0;
            end else if (cnt_q == STABLE_LAST) begin
               state_d = StRun;
               cnt_d   = '0;
            end
         end
         StRun: begin
            cnt_d = '0;
            if (!locked_s) begin
               if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
               retry_d = '0;
               state_d = StRstMmcm;
            end else if (bus.restart_req) begin
               retry_d = '0;
               state_d = StRstMmcm;
            end else if (bus.sel_valid && (bus.sel_req != sel_q)) begin
               pend_d  = bus.sel_req;
               state_d = StDrain;
            end
         end
         StDrain: begin
            // Lock loss is ignored here; the MMCM is reset on exit anyway.
            if (cnt_q == DRAIN_LAST) begin
               sel_d   = pend_q;
               retry_d = '0;
               state_d = StRstMmcm;
               cnt_d   = '0;
            end
         end
         StFail: begin
            cnt_d = '0;
            if (bus.sel_valid) begin
               sel_d   = bus.sel_req;
               retry_d = '0;
               state_d = StRstMmcm;
            end else if (bus.restart_req) begin
               retry_d = '0;
               state_d = StRstMmcm;
            end
         end
         default: begin
            state_d = StRstMmcm;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are decoded from state_d so they switch together with the state register.
   always_ff @(posedge clk_in14mhz) begin
      if (reset) begin
         state_q      <= StRstMmcm;
         cnt_q        <= '0;
         retry_q      <= '0;
         loss_q       <= '0;
         sel_q        <= DEFAULT_SEL;
         pend_q       <= DEFAULT_SEL;
         mmcm_reset_q <= 1'b1;
         sys_reset_q  <= 1'b1;
         running_q    <= 1'b0;
         fail_q       <= 1'b0;
         sel_busy_q   <= 1'b1;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         retry_q      <= retry_d;
         loss_q       <= loss_d;
         sel_q        <= sel_d;
         pend_q       <= pend_d;
         mmcm_reset_q <= (state_d == StRstMmcm) || (state_d == StFail);
         sys_reset_q  <= (state_d != StRun);
         running_q    <= (state_d == StRun);
         fail_q       <= (state_d == StFail);
         sel_busy_q   <= !((state_d == StRun) || (state_d == StFail));
      end
   end

   assign bus.mmcm_reset  = mmcm_reset_q;
   assign bus.sys_reset   = sys_reset_q;
   assign bus.clk_sel     = sel_q;
   assign bus.running     = running_q;
   assign bus.fail        = fail_q;
   assign bus.sel_busy    = sel_busy_q;
   assign bus.retry_count = retry_q;
   assign bus.loss_count  = loss_q;

endmodule

// File: tb/tb_clockgen_lock_sequencer.sv
// Bench for clockgen_lock_sequencer with short timing parameters.
// Each scenario task pushes expected output snapshots (indexed by cycle k after the last
// reset edge) into a scoreboard queue, then steps the clock, popping and comparing
// as each cycle's outputs appear. Snapshot order:
//   {mmcm_reset, sys_reset, clk_sel, running, fail, sel_busy, retry_count[3:0], loss_count[7:0]}
module tb_clockgen_lock_sequencer;

   typedef struct {
      int          at;
      logic [17:0] exp;
      string       tag;
   } sb_t;

   logic        clk;
   logic        rst;
   logic [17:0] obs;
   sb_t         sb[$];
   int          n_vec = 0;
   int          n_err = 0;

   clockgen_lock_sequencer_if sif ();

   clockgen_lock_sequencer #(
      .RST_CYCLES   (4),
      .LOCK_TIMEOUT (32),
      .STABLE_CYCLES(8),
      .MAX_RETRY    (2),
      .DRAIN_CYCLES (4),
      .DEFAULT_SEL  (1'b0),
      .CNT_W        (24)
   ) dut (
      .clk_in14mhz(clk),
      .reset      (rst),
      .bus        (sif.slave)
   );

   assign obs = {sif.mmcm_reset, sif.sys_reset, sif.clk_sel, sif.running, sif.fail,
                 sif.sel_busy, sif.retry_count, sif.loss_count};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [17:0] mk(bit mr, bit sr, bit cs, bit rn, bit fl, bit bz,
                                      logic [3:0] rc, logic [7:0] lc);
      return {mr, sr, cs, rn, fl, bz, rc, lc};
   endfunction

   function automatic sb_t ent(int at, logic [17:0] exp, string tag);
      sb_t e;
      e.at  = at;
      e.exp = exp;
      e.tag = tag;
      return e;
   endfunction

   // Leaves reset asserted at a negedge; the caller's cycle k=0 drops it.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      sif.locked = 1'b0;
      sif.restart_req = 1'b0;
      sif.sel_valid = 1'b0;
      sif.sel_req = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      sb_t e;
      do_reset();
      for (int k = 0; k <= 5; k++) sb.push_back(ent(k, mk(k < 4, 1, 0, 0, 0, 1, 0, 0), "reset"));
      for (int k = 0; k <= 5; k++) begin
         while (sb.size() != 0 && sb[0].at == k) begin
            e = sb.pop_front();
            n_vec++;
            if (obs !== e.exp) begin
               n_err++;
               $display("FAIL %s k=%0d got=%05h exp=%05h", e.tag, k, obs, e.exp);
            end
         end
         rst = 1'b0;
         @(negedge clk);
      end
      sb.delete();
   endtask

   task automatic test_nominal();
      sb_t e;
      do_reset();
      for (int k = 0; k <= 22; k++)
         sb.push_back(ent(k, mk(k < 4, k < 20, 0, k >= 20, 0, k < 20, 0, 0), "nominal"));
      for (int k = 0; k <= 22; k++) begin
         while (sb.size() != 0 && sb[0].at == k) begin
            e = sb.pop_front();
            n_vec++;
            if (obs !== e.exp) begin
               n_err++;
               $display("FAIL %s k=%0d got=%05h exp=%05h", e.tag, k, obs, e.exp);
            end
         end
         rst = 1'b0;
         sif.locked = (k >= 9);
         @(negedge clk);
      end
      sb.delete();
   endtask

   task automatic test_timeout();
      sb_t e;
      do_reset();
      for (int k = 0; k <= 117; k++) begin
         if (k <= 107)
            sb.push_back(ent(k, mk((k % 36) < 4, 1, 0, 0, 0, 1, 4'(k / 36), 0), "timeout"));
         else if (k <= 111)
            sb.push_back(ent(k, mk(1, 1, 0, 0, 1, 0, 2, 0), "fail_hold"));
         else
            sb.push_back(ent(k, mk(k < 116, 1, 0, 0, 0, 1, 0, 0), "fail_restart"));
      end
      for (int k = 0; k <= 117; k++) begin
         while (sb.size() != 0 && sb[0].at == k) begin
            e = sb.pop_front();
            n_vec++;
            if (obs !== e.exp) begin
               n_err++;
               $display("FAIL %s k=%0d got=%05h exp=%05h", e.tag, k, obs, e.exp);
            end
         end
         rst = 1'b0;
         sif.restart_req = (k == 111);
         @(negedge clk);
      end
      sb.delete();
   endtask

   task automatic test_glitch();
      sb_t e;
      do_reset();
      for (int k = 0; k <= 29; k++)
         sb.push_back(ent(k, mk(k < 4, k < 27, 0, k >= 27, 0, k < 27, 0, 0), "stable_glitch"));
      for (int k = 0; k <= 29; k++) begin
         while (sb.size() != 0 && sb[0].at == k) begin
            e = sb.pop_front();
            n_vec++;
            if (obs !== e.exp) begin
               n_err++;
               $display("FAIL %s k=%0d got=%05h exp=%05h", e.tag, k, obs, e.exp);
            end
         end
         rst = 1'b0;
         sif.locked = (k >= 9) && (k != 15);
         @(negedge clk);
      end
      sb.delete();
   endtask

   task automatic test_lock_loss();
      sb_t e;
      int  last;
      do_reset();
      last = 20 + 300 * 20 - 1;
      sb.push_back(ent(0, mk(1, 1, 0, 0, 0, 1, 0, 0), "loss_reset"));
      sb.push_back(ent(20, mk(0, 0, 0, 1, 0, 0, 0, 0), "loss_run"));
      for (int i = 0; i < 300; i++) begin
         sb.push_back(ent(20 + 20 * i + 2,
                          mk(0, 0, 0, 1, 0, 0, 0, 8'((i < 255) ? i : 255)), "loss_pre"));
         sb.push_back(ent(20 + 20 * i + 3,
                          mk(1, 1, 0, 0, 0, 1, 0, 8'((i + 1 < 255) ? i + 1 : 255)), "loss_hit"));
         sb.push_back(ent(20 + 20 * i + 16,
                          mk(0, 0, 0, 1, 0, 0, 0, 8'((i + 1 < 255) ? i + 1 : 255)), "loss_rerun"));
      end
      for (int k = 0; k <= last; k++) begin
         while (sb.size() != 0 && sb[0].at == k) begin
            e = sb.pop_front();
            n_vec++;
            if (obs !== e.exp) begin
               n_err++;
               $display("FAIL %s k=%0d got=%05h exp=%05h", e.tag, k, obs, e.exp);
            end
         end
         rst = 1'b0;
         if (k < 20) sif.locked = (k >= 9);
         else        sif.locked = ((k - 20) % 20) >= 4;
         @(negedge clk);
      end
      sb.delete();
   endtask

   task automatic test_select();
      sb_t e;
      do_reset();
      sb.push_back(ent(0, mk(1, 1, 0, 0, 0, 1, 0, 0), "sel_reset"));
      for (int k = 20; k <= 22; k++) sb.push_back(ent(k, mk(0, 0, 0, 1, 0, 0, 0, 0), "sel_run"));
      for (int k = 23; k <= 26; k++) sb.push_back(ent(k, mk(0, 1, 0, 0, 0, 1, 0, 0), "sel_drain"));
      for (int k = 27; k <= 30; k++) sb.push_back(ent(k, mk(1, 1, 1, 0, 0, 1, 0, 0), "sel_mmcm"));
      sb.push_back(ent(31, mk(0, 1, 1, 0, 0, 1, 0, 0), "sel_wait"));
      sb.push_back(ent(39, mk(0, 1, 1, 0, 0, 1, 0, 0), "sel_stable"));
      sb.push_back(ent(40, mk(0, 0, 1, 1, 0, 0, 0, 0), "sel_rerun"));
      sb.push_back(ent(44, mk(0, 0, 1, 1, 0, 0, 0, 0), "sel_preloss"));
      sb.push_back(ent(45, mk(1, 1, 1, 0, 0, 1, 0, 1), "sel_loss"));
      sb.push_back(ent(49, mk(0, 1, 1, 0, 0, 1, 0, 1), "busy_wait"));
      sb.push_back(ent(51, mk(0, 1, 1, 0, 0, 1, 0, 1), "busy_drop"));
      sb.push_back(ent(63, mk(0, 0, 1, 1, 0, 0, 0, 1), "busy_run"));
      sb.push_back(ent(65, mk(0, 0, 1, 1, 0, 0, 0, 1), "sel_same"));
      for (int k = 0; k <= 66; k++) begin
         while (sb.size() != 0 && sb[0].at == k) begin
            e = sb.pop_front();
            n_vec++;
            if (obs !== e.exp) begin
               n_err++;
               $display("FAIL %s k=%0d got=%05h exp=%05h", e.tag, k, obs, e.exp);
            end
         end
         rst = 1'b0;
         sif.locked = (k >= 9 && k < 42) || (k >= 52);
         sif.sel_valid = (k == 22) || (k == 50) || (k == 64);
         sif.sel_req = (k == 22) || (k == 64);
         @(negedge clk);
      end
      sb.delete();
   endtask

   task automatic test_simultaneous();
      sb_t e;
      do_reset();
      sb.push_back(ent(0, mk(1, 1, 0, 0, 0, 1, 0, 0), "simul_reset"));
      sb.push_back(ent(20, mk(0, 0, 0, 1, 0, 0, 0, 0), "simul_run"));
      sb.push_back(ent(24, mk(0, 0, 0, 1, 0, 0, 0, 0), "simul_pre"));
      sb.push_back(ent(25, mk(1, 1, 0, 0, 0, 1, 0, 1), "simul_hit"));
      sb.push_back(ent(30, mk(0, 1, 0, 0, 0, 1, 0, 1), "simul_sel"));
      for (int k = 0; k <= 31; k++) begin
         while (sb.size() != 0 && sb[0].at == k) begin
            e = sb.pop_front();
            n_vec++;
            if (obs !== e.exp) begin
               n_err++;
               $display("FAIL %s k=%0d got=%05h exp=%05h", e.tag, k, obs, e.exp);
            end
         end
         rst = 1'b0;
         sif.locked = (k >= 9) && (k < 22);
         sif.restart_req = (k == 24);
         sif.sel_valid = (k == 24);
         sif.sel_req = (k == 24);
         @(negedge clk);
      end
      sb.delete();
   endtask

   task automatic test_midreset();
      sb_t e;
      do_reset();
      sb.push_back(ent(0, mk(1, 1, 0, 0, 0, 1, 0, 0), "mid_reset0"));
      sb.push_back(ent(20, mk(0, 0, 0, 1, 0, 0, 0, 0), "mid_run"));
      sb.push_back(ent(23, mk(0, 1, 0, 0, 0, 1, 0, 0), "mid_drain"));
      sb.push_back(ent(24, mk(0, 1, 0, 0, 0, 1, 0, 0), "mid_drain"));
      for (int k = 25; k <= 30; k++) sb.push_back(ent(k, mk(1, 1, 0, 0, 0, 1, 0, 0), "mid_rst"));
      sb.push_back(ent(31, mk(0, 1, 0, 0, 0, 1, 0, 0), "mid_wait"));
      for (int k = 0; k <= 32; k++) begin
         while (sb.size() != 0 && sb[0].at == k) begin
            e = sb.pop_front();
            n_vec++;
            if (obs !== e.exp) begin
               n_err++;
               $display("FAIL %s k=%0d got=%05h exp=%05h", e.tag, k, obs, e.exp);
            end
         end
         rst = (k >= 24) && (k <= 26);
         sif.locked = (k >= 9);
         sif.sel_valid = (k == 22);
         sif.sel_req = (k == 22);
         @(negedge clk);
      end
      sb.delete();
   endtask

   initial begin
      rst = 1'b1;
      sif.locked = 1'b0;
      sif.restart_req = 1'b0;
      sif.sel_valid = 1'b0;
      sif.sel_req = 1'b0;
      test_reset();
      test_nominal();
      test_timeout();
      test_glitch();
      test_lock_loss();
      test_select();
      test_simultaneous();
      test_midreset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
